// File: rtl/stb_sample_acc.sv
// stb_sample_acc: counts strobe events and the comparator level sampled with
// each one, from stb_i/cmp_i that arrive asynchronously. An acquisition of
// nsamp_i strobes returns ones/total through a valid/ready handshake.
// Optional macro STB_SAMPLE_TIMEOUT_EN adds a watchdog. The watchdog ends a
// stalled acquisition with err_o set and the partial counts.
module stb_sample_acc #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stb_i,
  input  logic                 gen_rdy_i,
  input  logic                 cmp_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] nsamp_i,
  output logic                 busy_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] ones_o,
  output logic [CNT_WIDTH-1:0] total_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_ACC      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // synchronizers and event pipeline
  logic r_stb_s1, r_stb_s2, r_stb_s3;
  logic r_cmp_s1, r_cmp_s2;
  logic r_evt, r_evt_cmp;
  logic w_evt;

  // control and result registers
  state_t               r_state, w_state_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [CNT_WIDTH-1:0] r_ones, w_ones_nxt;
  logic [CNT_WIDTH-1:0] r_total, w_total_nxt;
  logic [CNT_WIDTH-1:0] r_nsamp, w_nsamp_nxt;
  logic [CNT_WIDTH-1:0] w_total_inc;

`ifdef STB_SAMPLE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic            r_err, w_err_nxt;
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            w_to;
  logic            w_cnt_evt;
`endif

  // A rising edge on the second sync stage is an event. cmp is taken from the
  // same stage, so the counted level is the one captured with the strobe.
  assign w_evt       = r_stb_s2 & ~r_stb_s3;
  assign w_total_inc = r_total + CNT_WIDTH'(1);

  // Two-flop synchronizers, then one register stage that holds the event
  // and its cmp level. Counters therefore update on the 3rd edge after
  // capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stb_s1  <= 1'b0;
      r_stb_s2  <= 1'b0;
      r_stb_s3  <= 1'b0;
      r_cmp_s1  <= 1'b0;
      r_cmp_s2  <= 1'b0;
      r_evt     <= 1'b0;
      r_evt_cmp <= 1'b0;
    end else begin
      r_stb_s1  <= stb_i;
      r_stb_s2  <= r_stb_s1;
      r_stb_s3  <= r_stb_s2;
      r_cmp_s1  <= cmp_i;
      r_cmp_s2  <= r_cmp_s1;
      r_evt     <= w_evt;
      r_evt_cmp <= r_cmp_s2;
    end
  end

`ifdef STB_SAMPLE_TIMEOUT_EN
  assign w_to      = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_cnt_evt = (r_state == S_ACC) && gen_rdy_i && r_evt;
`endif

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ones  <= '0;
      r_total <= '0;
      r_nsamp <= '0;
`ifdef STB_SAMPLE_TIMEOUT_EN
      r_err   <= 1'b0;
      r_wdog  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_ones  <= w_ones_nxt;
      r_total <= w_total_nxt;
      r_nsamp <= w_nsamp_nxt;
`ifdef STB_SAMPLE_TIMEOUT_EN
      r_err   <= w_err_nxt;
      r_wdog  <= w_wdog_nxt;
`endif
    end
  end

  // Next-state and next-output logic; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_ones_nxt  = r_ones;
    w_total_nxt = r_total;
    w_nsamp_nxt = r_nsamp;
`ifdef STB_SAMPLE_TIMEOUT_EN
    w_err_nxt   = r_err;
    w_wdog_nxt  = '0;
`endif

    case (r_state)
      S_IDLE: begin
        if (start_i && (nsamp_i != '0)) begin
          w_nsamp_nxt = nsamp_i;
          w_ones_nxt  = '0;
          w_total_nxt = '0;
`ifdef STB_SAMPLE_TIMEOUT_EN
          w_err_nxt   = 1'b0;
`endif
          w_state_nxt = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (gen_rdy_i) begin
          w_state_nxt = S_ACC;
        end
`ifdef STB_SAMPLE_TIMEOUT_EN
        else if (w_to) begin
          w_err_nxt   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_ACC: begin
        if (!gen_rdy_i) begin
          w_ones_nxt  = '0;
          w_total_nxt = '0;
          w_state_nxt = S_WAIT_RDY;
        end else if (r_evt) begin
          w_total_nxt = w_total_inc;
          w_ones_nxt  = r_ones + CNT_WIDTH'(r_evt_cmp);
          if (w_total_inc == r_nsamp) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
`ifdef STB_SAMPLE_TIMEOUT_EN
        else if (w_to) begin
          w_err_nxt   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (ready_i) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort_i) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_ones_nxt  = '0;
      w_total_nxt = '0;
    end

`ifdef STB_SAMPLE_TIMEOUT_EN
    // Watchdog restarts on entry to WAIT_RDY/ACC and on each counted event
    if ((w_state_nxt == S_WAIT_RDY) || (w_state_nxt == S_ACC)) begin
      if ((w_state_nxt != r_state) || w_cnt_evt) begin
        w_wdog_nxt = '0;
      end else begin
        w_wdog_nxt = r_wdog + WD_W'(1);
      end
    end
`endif

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign busy_o  = r_busy;
  assign valid_o = r_valid;
  assign ones_o  = r_ones;
  assign total_o = r_total;
`ifdef STB_SAMPLE_TIMEOUT_EN
  assign err_o   = r_err;
`else
  assign err_o   = 1'b0;
`endif

endmodule
